fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, the PC value loaded on reset.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port stall  input  1  decode does not consume the IF/ID contents this cycle.
REQ-005 Port branch_taken  input  1  redirect request from the execute stage.
REQ-006 Port branch_pc  input  32  PC of the taken branch instruction.
REQ-007 Port branch_imm  input  32  sign-extended B-type byte offset (bit 0 = 0) from the immediate generator.
REQ-008 Port imem_req  output  1  instruction-memory read request.
REQ-009 Port imem_addr  output  32  word-aligned read address; bits [1:0] are always 2'b00.
REQ-010 Port imem_ready  input  1  read data is valid this cycle for the outstanding request.
REQ-011 Port imem_rdata  input  32  instruction word; sampled only when imem_ready=1.
REQ-012 Port if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 Port if_id_instr  output  32  IF/ID instruction; feeds the immediate generator and decode.
REQ-014 Port if_id_pc  output  32  PC of if_id_instr.

Function
REQ-015 FSM states: IDLE, FETCH, DRAIN, HOLD; all outputs are registered.
REQ-016 imem_req = 1 in FETCH and DRAIN and 0 in IDLE and HOLD; imem_addr = pc.
REQ-017 imem_addr and imem_req are held stable while imem_req=1 and imem_ready=0.
REQ-018 IDLE -> FETCH unconditionally on the first clock edge after reset is released.
REQ-019 "IF/ID free" = !if_id_valid | !stall.
REQ-020 FETCH, imem_ready=1, IF/ID free: IF/ID <= {1, imem_rdata, pc}; pc <= pc+4; remain in FETCH.
REQ-021 FETCH, imem_ready=1, IF/ID not free: buffer <= {imem_rdata, pc}; pc <= pc+4; -> HOLD.
REQ-022 HOLD, IF/ID free: IF/ID <= {1, buffer}; -> FETCH.
REQ-023 HOLD, IF/ID not free: hold all state.
REQ-024 In any state with no load, IF/ID clears valid when !stall and holds its value when stall=1.
REQ-025 Redirect target = (branch_pc + branch_imm) mod 2^32 with bits [1:0] forced to 0; wrap-around is silent.
REQ-026 branch_taken has priority over stall, imem_ready and the buffer; it always clears if_id_valid on the same edge.
REQ-027 branch_taken in FETCH with imem_ready=1: discard imem_rdata; pc <= target; remain in FETCH.
REQ-028 branch_taken in FETCH with imem_ready=0: pc_next <= target; -> DRAIN, keeping the old imem_addr.
REQ-029 DRAIN, imem_ready=1: discard imem_rdata; pc <= pc_next; -> FETCH.
REQ-030 branch_taken in DRAIN: overwrite pc_next with the new target.
REQ-031 branch_taken in HOLD: discard the buffer; pc <= target; -> FETCH.
REQ-032 branch_taken in IDLE: pc <= target; -> FETCH.
REQ-033 Latency: with imem_ready=1 every FETCH cycle and stall=0, one instruction enters IF/ID per cycle.
REQ-034 Redirect penalty: the first target instruction appears in IF/ID no earlier than 2 cycles after branch_taken.

Reset
REQ-035 While reset=1, and immediately on its assertion: state=IDLE, pc=RESET_PC, pc_next=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, buffer=0.
REQ-036 Reset asserted mid-request abandons the request without waiting for imem_ready; any later imem_ready is ignored until FETCH is re-entered.

Verification
REQ-037 Bench: release reset, imem_ready=1 every cycle, rdata = 0x00000013 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; if_id_pc follows, one cycle later.
REQ-038 Bench: stall=1 with IF/ID full while a response arrives at pc=0x10 -> HOLD, imem_req=0; release stall -> if_id_pc=0x10 then 0x14, with no instruction lost or duplicated.
REQ-039 Bench: branch_taken, branch_pc=0x20, branch_imm=0xFFFFFFF8, imem_ready=1 the same cycle -> response dropped, if_id_valid=0, next imem_addr=0x18.
REQ-040 Bench: branch_taken while imem_ready=0 at addr 0x40, target 0x100 -> DRAIN holds addr 0x40 until ready; response discarded; next imem_addr=0x100.
REQ-041 Bench: branch_pc=0xFFFFFFF0, branch_imm=0x20 -> imem_addr=0x00000010 (wrap).
REQ-042 Bench: assert reset during DRAIN -> all outputs take their REQ-035 values immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, fills the IF/ID
// register, parks one response in a skid buffer under stall, and handles redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [1:0]  dbg_state
);

  // imem handshake: a read is outstanding while imem_req=1; imem_addr stays
  // stable until a cycle with imem_ready=1 completes it (reset abandons it).
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        req_q, req_d;

  logic        if_free;
  logic [31:0] target;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_next_d   = pc_next_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    if_free     = !valid_q || !stall;
    target      = (branch_pc + branch_imm) & 32'hFFFF_FFFC;

    // Without a load, decode either consumes the entry or keeps it.
    if (!stall) valid_d = 1'b0;

    if (branch_taken) begin
      valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ready) pc_d = target;
          else begin
            pc_next_d = target;
            state_d   = S_DRAIN;
          end
        end
        S_DRAIN: begin
          pc_next_d = target;
          if (imem_ready) begin
            pc_d    = target;
            state_d = S_FETCH;
          end
        end
        default: begin
          pc_d    = target;
          state_d = S_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            pc_d = pc_q + 32'd4;
            if (if_free) begin
              valid_d = 1'b1;
              instr_d = imem_rdata;
              ipc_d   = pc_q;
            end else begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = pc_q;
              state_d     = S_HOLD;
            end
          end
        end
        S_DRAIN: begin
          // The wrong-path response is dropped; only then does the target go out.
          if (imem_ready) begin
            pc_d    = pc_next_q;
            state_d = S_FETCH;
          end
        end
        S_HOLD: begin
          if (if_free) begin
            valid_d = 1'b1;
            instr_d = buf_instr_q;
            ipc_d   = buf_pc_q;
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pc_next_q   <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc_q    <= 32'd0;
      valid_q     <= 1'b0;
      instr_q     <= 32'd0;
      ipc_q       <= 32'd0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_next_q   <= pc_next_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      req_q       <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ipc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked against
// an in-order instruction-stream model (next expected PC, redirected by branches).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_imm;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_imm(branch_imm), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_pc = 32'd0; branch_imm = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic stream_until(input logic [31:0] addr);
    int n = 0;
    imem_ready = 1'b1; stall = 1'b0;
    while (imem_addr !== addr && n < 200) begin
      imem_rdata = instr_of(imem_addr);
      tick();
      n++;
    end
    total++;
    if (imem_addr !== addr) begin
      bad++; $display("FAIL stream_until addr=%h want=%h", imem_addr, addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_pc = 32'd0; branch_imm = 32'd0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    total++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, dbg_state} !==
        {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, ST_IDLE}) begin
      bad++; $display("FAIL reset req=%b addr=%h v=%b instr=%h pc=%h st=%0d want all zero/IDLE",
                      imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, dbg_state);
    end
  endtask

  task automatic test_stream();
    do_reset();
    imem_ready = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL stream_first req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, if_id_valid);
    end
    tick();
    total++;
    if (imem_addr !== 32'h4 || if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h13) begin
      bad++; $display("FAIL stream_second addr=%h v=%b pc=%h instr=%h want 4/1/0/13",
                      imem_addr, if_id_valid, if_id_pc, if_id_instr);
    end
    tick();
    total++;
    if (imem_addr !== 32'h8 || if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
      bad++; $display("FAIL stream_third addr=%h v=%b pc=%h want 8/1/4", imem_addr, if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_hold();
    do_reset();
    stream_until(32'h10);
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = instr_of(32'h10);
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (dbg_state !== ST_HOLD || imem_req !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc !== 32'hC) begin
        bad++; $display("FAIL hold_%0d st=%0d req=%b v=%b pc=%h want HOLD/0/1/c",
                        i, dbg_state, imem_req, if_id_valid, if_id_pc);
      end
      imem_rdata = 32'hBAD0_BAD0;
      tick();
    end
    stall = 1'b0; imem_ready = 1'b0;
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 || if_id_instr !== instr_of(32'h10) ||
        imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      bad++; $display("FAIL hold_release v=%b pc=%h instr=%h req=%b addr=%h want 1/10/%h/1/14",
                      if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr, instr_of(32'h10));
    end
    imem_ready = 1'b1; imem_rdata = instr_of(imem_addr);
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h14 || if_id_instr !== instr_of(32'h14)) begin
      bad++; $display("FAIL hold_next v=%b pc=%h instr=%h want 1/14", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_branch_ready();
    do_reset();
    stream_until(32'h8);
    branch_taken = 1'b1; branch_pc = 32'h20; branch_imm = 32'hFFFF_FFF8;
    imem_ready = 1'b1; imem_rdata = instr_of(32'h8);
    tick();
    branch_taken = 1'b0;
    total++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'h18 || imem_req !== 1'b1 || dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL branch_ready v=%b addr=%h req=%b st=%0d want 0/18/1/FETCH",
                      if_id_valid, imem_addr, imem_req, dbg_state);
    end
    imem_rdata = instr_of(imem_addr);
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h18 || if_id_instr !== instr_of(32'h18)) begin
      bad++; $display("FAIL branch_target v=%b pc=%h instr=%h want 1/18", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_drain();
    do_reset();
    stream_until(32'h40);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_pc = 32'hF0; branch_imm = 32'h10;
    tick();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dbg_state !== ST_DRAIN || imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
        bad++; $display("FAIL drain_%0d st=%0d req=%b addr=%h v=%b want DRAIN/1/40/0",
                        i, dbg_state, imem_req, imem_addr, if_id_valid);
      end
      if (i < 2) tick();
    end
    imem_ready = 1'b1; imem_rdata = instr_of(32'h40);
    tick();
    total++;
    if (dbg_state !== ST_FETCH || imem_addr !== 32'h100 || if_id_valid !== 1'b0) begin
      bad++; $display("FAIL drain_exit st=%0d addr=%h v=%b want FETCH/100/0", dbg_state, imem_addr, if_id_valid);
    end
    imem_rdata = instr_of(imem_addr);
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100) begin
      bad++; $display("FAIL drain_target v=%b pc=%h want 1/100", if_id_valid, if_id_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1; imem_rdata = instr_of(32'h0);
    tick();
    branch_taken = 1'b1; branch_pc = 32'hFFFF_FFF0; branch_imm = 32'h20;
    tick();
    total++;
    if (imem_addr !== 32'h10) begin
      bad++; $display("FAIL wrap addr=%h want 10", imem_addr);
    end
    branch_pc = 32'h0000_0102; branch_imm = 32'h0;
    tick();
    branch_taken = 1'b0;
    total++;
    if (imem_addr !== 32'h100) begin
      bad++; $display("FAIL align addr=%h want 100", imem_addr);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    stream_until(32'h0C);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_pc = 32'h200; branch_imm = 32'h0;
    tick();
    branch_taken = 1'b0;
    total++;
    if (dbg_state !== ST_DRAIN) begin
      bad++; $display("FAIL rid_pre st=%0d want DRAIN", dbg_state);
    end
    reset = 1'b1;
    #1;
    total++;
    if ({imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, dbg_state} !==
        {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, ST_IDLE}) begin
      bad++; $display("FAIL rid_async req=%b addr=%h v=%b instr=%h pc=%h st=%0d want reset values",
                      imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc, dbg_state);
    end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL rid_restart req=%b addr=%h v=%b st=%0d want 1/0/0/FETCH",
                      imem_req, imem_addr, if_id_valid, dbg_state);
    end
    imem_rdata = instr_of(imem_addr);
    tick();
    total++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== instr_of(32'h0)) begin
      bad++; $display("FAIL rid_first v=%b pc=%h instr=%h want 1/0", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_random();
    int consumed = 0;
    int errs = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    logic [31:0] exp_pc;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      imem_ready   = imem_req ? ($urandom_range(0, 2) != 0) : 1'b0;
      imem_rdata   = instr_of(imem_addr);
      stall        = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 15) == 0);
      branch_pc    = $urandom;
      branch_imm   = $urandom_range(0, 4095) - 2048;
      branch_imm   = branch_imm & 32'hFFFF_FFFE;
      if (pend && imem_addr !== pend_addr) begin
        errs++;
        if (errs < 10) $display("FAIL rand_addr_stable cyc=%0d addr=%h want %h", cyc, imem_addr, pend_addr);
      end
      if (imem_addr[1:0] !== 2'b00) begin
        errs++;
        if (errs < 10) $display("FAIL rand_align cyc=%0d addr=%h", cyc, imem_addr);
      end
      if (branch_taken) begin
        exp_q.delete();
        exp_q.push_back((branch_pc + branch_imm) & 32'hFFFF_FFFC);
      end else if (if_id_valid && !stall) begin
        exp_pc = exp_q.pop_front();
        exp_q.push_back(exp_pc + 32'd4);
        consumed++;
        if (if_id_pc !== exp_pc || if_id_instr !== instr_of(exp_pc)) begin
          errs++;
          if (errs < 10) $display("FAIL rand_stream cyc=%0d pc=%h instr=%h want pc=%h instr=%h",
                                  cyc, if_id_pc, if_id_instr, exp_pc, instr_of(exp_pc));
        end
      end
      pend      = imem_req && !imem_ready;
      pend_addr = imem_addr;
      tick();
    end
    branch_taken = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL rand_errors count=%0d want 0", errs);
    end
    total++;
    if (consumed < 100) begin
      bad++; $display("FAIL rand_progress consumed=%0d want >=100", consumed);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_pc = 32'd0;
    branch_imm = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    tick();
    test_reset();
    test_stream();
    test_hold();
    test_branch_ready();
    test_drain();
    test_wrap();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
